// File: rtl/ula_seq_ctrl.sv
// ula_seq_ctrl: sequences a wide operation through one shared 8-bit ALU.
// The ALU works one byte per cycle, LSB first. Each byte's carry-out feeds
// the next byte's carry-in. The sequencer assembles the wide result, the
// final carry and the whole-word A=B flag, then pulses done for one cycle.
module ula_seq_ctrl #(
   parameter int NBYTES = 4
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic [8*NBYTES-1:0]   op_a,
   input  logic [8*NBYTES-1:0]   op_b,
   input  logic [3:0]            op_s,
   input  logic                  op_m,
   input  logic                  op_cin,
   output logic                  busy,
   output logic                  done,
   output logic [8*NBYTES-1:0]   result,
   output logic                  res_cout,
   output logic                  res_eq,
   output logic [7:0]            alu_a,
   output logic [7:0]            alu_b,
   output logic [3:0]            alu_s,
   output logic                  alu_m,
   output logic                  alu_cin,
   input  logic [7:0]            alu_f,
   input  logic                  alu_aeqb,
   input  logic                  alu_cout
);

   localparam int IW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
   localparam logic [IW-1:0] LAST_IDX = IW'(NBYTES - 1);

   typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

   state_t                state_reg;
   logic [8*NBYTES-1:0]   a_reg;
   logic [8*NBYTES-1:0]   b_reg;
   logic [8*NBYTES-1:0]   result_reg;
   logic [3:0]            s_reg;
   logic                  m_reg;
   logic                  carry_reg;
   logic                  eq_reg;
   logic                  busy_reg;
   logic                  done_reg;
   logic [IW-1:0]         idx_reg;

   // Byte offset of the current slice. The three zero LSBs multiply by 8 with no width growth surprises.
   logic [IW+2:0]         bit_ofs;
   assign bit_ofs = {idx_reg, 3'b000};

   // Control FSM: latch operands, walk the bytes, then pulse done for one cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_reg  <= S_IDLE;
         a_reg      <= '0;
         b_reg      <= '0;
         s_reg      <= '0;
         m_reg      <= 1'b0;
         result_reg <= '0;
         carry_reg  <= 1'b0;
         eq_reg     <= 1'b0;
         idx_reg    <= '0;
         busy_reg   <= 1'b0;
         done_reg   <= 1'b0;
      end else begin
         case (state_reg)
            S_IDLE: begin
               if (start) begin
                  a_reg     <= op_a;
                  b_reg     <= op_b;
                  s_reg     <= op_s;
                  m_reg     <= op_m;
                  idx_reg   <= '0;
                  carry_reg <= op_cin;
                  eq_reg    <= 1'b1;
                  busy_reg  <= 1'b1;
                  state_reg <= S_RUN;
               end
            end
            S_RUN: begin
               result_reg[bit_ofs +: 8] <= alu_f;
               carry_reg <= alu_cout;
               eq_reg    <= eq_reg & alu_aeqb;
               if (idx_reg == LAST_IDX) begin
                  // Index stays on the last byte rather than wrapping.
                  busy_reg  <= 1'b0;
                  done_reg  <= 1'b1;
                  state_reg <= S_DONE;
               end else begin
                  idx_reg <= idx_reg + 1'b1;
               end
            end
            S_DONE: begin
               done_reg  <= 1'b0;
               state_reg <= S_IDLE;
            end
            default: begin
               busy_reg  <= 1'b0;
               done_reg  <= 1'b0;
               state_reg <= S_IDLE;
            end
         endcase
      end
   end

   // Present the current slice to the ALU only while running; otherwise drive zeros.
   always_comb begin
      alu_a   = 8'h00;
      alu_b   = 8'h00;
      alu_s   = 4'h0;
      alu_m   = 1'b0;
      alu_cin = 1'b0;
      if (state_reg == S_RUN) begin
         alu_a   = a_reg[bit_ofs +: 8];
         alu_b   = b_reg[bit_ofs +: 8];
         alu_s   = s_reg;
         alu_m   = m_reg;
         alu_cin = carry_reg;
      end
   end

   assign busy     = busy_reg;
   assign done     = done_reg;
   assign result   = result_reg;
   assign res_cout = carry_reg;
   assign res_eq   = eq_reg;

endmodule

// File: tb/tb_ula_seq_ctrl.sv
// Bench for ula_seq_ctrl with a behavioural 8-bit ALU attached to the alu_* ports.
module tb_ula_seq_ctrl;

   localparam int NB = 4;

   logic          clk;
   logic          rst;
   logic          start;
   logic [31:0]   op_a;
   logic [31:0]   op_b;
   logic [3:0]    op_s;
   logic          op_m;
   logic          op_cin;
   logic          busy;
   logic          done;
   logic [31:0]   result;
   logic          res_cout;
   logic          res_eq;
   logic [7:0]    alu_a;
   logic [7:0]    alu_b;
   logic [3:0]    alu_s;
   logic          alu_m;
   logic          alu_cin;
   logic [7:0]    alu_f;
   logic          alu_aeqb;
   logic          alu_cout;

   int n_vec = 0;
   int n_bad = 0;

   ula_seq_ctrl #(.NBYTES(NB)) dut (
      .clk(clk), .rst(rst), .start(start),
      .op_a(op_a), .op_b(op_b), .op_s(op_s), .op_m(op_m), .op_cin(op_cin),
      .busy(busy), .done(done), .result(result),
      .res_cout(res_cout), .res_eq(res_eq),
      .alu_a(alu_a), .alu_b(alu_b), .alu_s(alu_s), .alu_m(alu_m), .alu_cin(alu_cin),
      .alu_f(alu_f), .alu_aeqb(alu_aeqb), .alu_cout(alu_cout)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Behavioural byte ALU: add, subtract (A + ~B + cin), pass A + cin, and a few logic ops.
   logic [8:0] sum9;
   always_comb begin
      sum9     = 9'h000;
      alu_f    = 8'h00;
      alu_cout = 1'b0;
      alu_aeqb = (alu_a == alu_b);
      if (alu_m) begin
         case (alu_s)
            4'b0000: alu_f = ~alu_a;
            4'b0110: alu_f = alu_a ^ alu_b;
            4'b1011: alu_f = alu_a & alu_b;
            4'b1110: alu_f = alu_a | alu_b;
            default: alu_f = alu_a;
         endcase
      end else begin
         case (alu_s)
            4'b0110: sum9 = {1'b0, alu_a} + {1'b0, ~alu_b} + {8'h00, alu_cin};
            4'b0000: sum9 = {1'b0, alu_a} + {8'h00, alu_cin};
            default: sum9 = {1'b0, alu_a} + {1'b0, alu_b} + {8'h00, alu_cin};
         endcase
         alu_f    = sum9[7:0];
         alu_cout = sum9[8];
      end
   end

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      logic [3:0]  s;
      logic        m;
      logic        cin;
      logic [31:0] res;
      logic        cout;
      logic        eq;
   } vec_t;

   vec_t vecs [8];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_vec++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   // One full operation, sampled 1 ns after every edge from the accept edge onward.
   task automatic run_op(input vec_t v, input bit intrude, input string tag);
      int busy_cnt;
      int done_cnt;
      int done_at;
      logic [31:0] res_at;
      logic c_at;
      logic e_at;
      busy_cnt = 0; done_cnt = 0; done_at = -1; res_at = '0; c_at = 1'b0; e_at = 1'b0;
      @(negedge clk);
      op_a = v.a; op_b = v.b; op_s = v.s; op_m = v.m; op_cin = v.cin; start = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      op_a = ~v.a; op_b = ~v.b; op_cin = ~v.cin;
      chk({tag, " alu_a byte0"}, {24'h0, alu_a}, {24'h0, v.a[7:0]});
      chk({tag, " alu_cin byte0"}, {31'h0, alu_cin}, {31'h0, v.cin});
      for (int i = 0; i <= NB + 1; i++) begin
         if (intrude && i == 1) begin
            start = 1'b1; op_a = 32'h1234_5678; op_b = 32'h0F0F_0F0F; op_s = 4'b0110; op_m = 1'b1;
         end
         if (intrude && i == 2) start = 1'b0;
         if (busy) busy_cnt++;
         if (done) begin
            done_cnt++; done_at = i; res_at = result; c_at = res_cout; e_at = res_eq;
         end
         if (i < NB + 1) begin
            @(posedge clk); #1;
         end
      end
      chk({tag, " busy cycles"}, busy_cnt, NB);
      chk({tag, " done pulses"}, done_cnt, 1);
      chk({tag, " done cycle"}, done_at, NB);
      chk({tag, " result"}, res_at, v.res);
      chk({tag, " res_cout"}, {31'h0, c_at}, {31'h0, v.cout});
      chk({tag, " res_eq"}, {31'h0, e_at}, {31'h0, v.eq});
      chk({tag, " result held"}, result, v.res);
      chk({tag, " alu idle"}, {alu_a, alu_b, alu_s, alu_m, alu_cin, 10'h0}, 32'h0);
      $display("op %s: A=%h B=%h S=%b M=%b cin=%b -> F=%h cout=%b eq=%b",
               tag, v.a, v.b, v.s, v.m, v.cin, res_at, c_at, e_at);
   endtask

   initial begin
      int dcnt;
      int d0;
      int d1;
      logic [31:0] zero32;
      zero32 = 32'h0;

      vecs[0] = '{32'h0000_FFFF, 32'h0000_0001, 4'b1001, 1'b0, 1'b0, 32'h0001_0000, 1'b0, 1'b0};
      vecs[1] = '{32'hFFFF_FFFF, 32'h0000_0001, 4'b1001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b0};
      vecs[2] = '{32'hAAAA_AAAA, 32'hAAAA_AAAA, 4'b0000, 1'b1, 1'b0, 32'h5555_5555, 1'b0, 1'b1};
      vecs[3] = '{32'hAAAA_AAAA, 32'h2AAA_AAAA, 4'b0000, 1'b1, 1'b0, 32'h5555_5555, 1'b0, 1'b0};
      vecs[4] = '{32'h1234_5678, 32'h0234_5677, 4'b0110, 1'b0, 1'b1, 32'h1000_0001, 1'b1, 1'b0};
      vecs[5] = '{32'h0000_0000, 32'h0000_0000, 4'b1001, 1'b0, 1'b1, 32'h0000_0001, 1'b0, 1'b1};
      vecs[6] = '{32'hF0F0_F0F0, 32'hFF00_FF00, 4'b0110, 1'b1, 1'b0, 32'h0FF0_0FF0, 1'b0, 1'b0};
      vecs[7] = '{32'h8000_0000, 32'h8000_0000, 4'b1001, 1'b0, 1'b0, 32'h0000_0000, 1'b1, 1'b1};

      rst = 1'b0; start = 1'b0; op_a = '0; op_b = '0; op_s = '0; op_m = 1'b0; op_cin = 1'b0;
      // Asynchronous reset asserted before the first clock edge.
      #1 rst = 1'b1;
      #1;
      chk("reset busy", {31'h0, busy}, 32'h0);
      chk("reset done", {31'h0, done}, 32'h0);
      chk("reset result", result, zero32);
      chk("reset cout/eq", {30'h0, res_cout, res_eq}, 32'h0);
      chk("reset alu", {alu_a, alu_b, alu_s, alu_m, alu_cin, 10'h0}, 32'h0);
      repeat (2) @(posedge clk);
      @(negedge clk) rst = 1'b0;

      for (int k = 0; k < 8; k++) run_op(vecs[k], 1'b0, $sformatf("vec%0d", k));

      // start during the 2nd RUN cycle with other operands is ignored.
      run_op(vecs[0], 1'b1, "ignored_start");

      // Reset asserted mid-cycle during the 3rd RUN cycle.
      @(negedge clk);
      op_a = vecs[4].a; op_b = vecs[4].b; op_s = vecs[4].s; op_m = vecs[4].m; op_cin = vecs[4].cin;
      start = 1'b1;
      @(posedge clk); #1 start = 1'b0;
      @(posedge clk); #1;
      @(posedge clk); #3;
      chk("midrst busy before", {31'h0, busy}, 32'h1);
      rst = 1'b1;
      #1;
      chk("midrst busy", {31'h0, busy}, 32'h0);
      chk("midrst result", result, zero32);
      chk("midrst cout/eq/done", {29'h0, res_cout, res_eq, done}, 32'h0);
      chk("midrst alu", {alu_a, alu_b, alu_s, alu_m, alu_cin, 10'h0}, 32'h0);
      @(negedge clk) rst = 1'b0;
      dcnt = 0;
      for (int i = 0; i < 8; i++) begin
         @(posedge clk); #1;
         if (done) dcnt++;
      end
      chk("midrst no done", dcnt, 0);
      run_op(vecs[4], 1'b0, "after_reset");

      // start held high: back-to-back operations, one every NB+2 cycles.
      @(negedge clk);
      op_a = vecs[1].a; op_b = vecs[1].b; op_s = vecs[1].s; op_m = vecs[1].m; op_cin = vecs[1].cin;
      start = 1'b1;
      dcnt = 0; d0 = -1; d1 = -1;
      @(posedge clk); #1;
      for (int i = 0; i < 12; i++) begin
         if (done) begin
            if (dcnt == 0) d0 = i; else d1 = i;
            dcnt++;
            chk("b2b result", result, vecs[1].res);
         end
         if (i < 11) begin
            @(posedge clk); #1;
         end
      end
      start = 1'b0;
      chk("b2b done count", dcnt, 2);
      chk("b2b first done", d0, NB);
      chk("b2b spacing", d1 - d0, NB + 2);
      repeat (NB + 3) @(posedge clk);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

   // Absolute time limit so the run always ends.
   initial begin
      #200000;
      $display("FAIL timeout: simulation still running at %0t", $time);
      $fatal(1, "timeout");
   end

endmodule
